// File: rtl/led_pattern_counter_if.sv
// Pin-level bundle for the LED pattern engine: direction switch, enable and mode
// in; LED value, step tick, debounced direction and wrap/bounce event out.
interface led_pattern_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             switch_i;
  logic             en_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] l_o;
  logic             tick_o;
  logic             dir_db_o;
  logic             event_o;

  modport master (
    output switch_i, en_i, mode_i,
    input  l_o, tick_o, dir_db_o, event_o
  );

  modport slave (
    input  switch_i, en_i, mode_i,
    output l_o, tick_o, dir_db_o, event_o
  );
endinterface

// File: rtl/led_pattern_counter.sv
// LED pattern engine: prescaled step tick, synchronised/debounced direction switch,
// and a mode machine for wrap count, saturating count, ping-pong sweep and hold.
module led_pattern_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIV        = 25_000_000,
  parameter int unsigned DEB_CYCLES = 250_000
) (
  input  logic                  clk_in,
  input  logic                  rst,
  led_pattern_counter_if.slave  bus
);
  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0]    DEB_MAX   = DW'(DEB_CYCLES - 1);
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_WRAP = 2'b00,
    MODE_SAT  = 2'b01,
    MODE_PP   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  logic             sync1_q, sync2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic             dir_db_q, dir_db_d;
  mode_e            mode_q;
  mode_e            mode_in;
  logic [WIDTH-1:0] l_q;
  logic             pp_dir_q;
  logic             event_q;
  logic             sw_s;

  assign sw_s    = sync2_q;
  assign mode_in = mode_e'(bus.mode_i);

  // Prescaler: tick is registered so it is high while the count sits at DIV-1.
  always_comb begin
    presc_d = presc_q;
    if (bus.en_i) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
    tick_d = bus.en_i && (presc_d == PRESC_MAX);
  end

  // Debounce: direction follows only after DEB_CYCLES consecutive mismatches.
  always_comb begin
    deb_cnt_d = deb_cnt_q + DW'(1);
    dir_db_d  = dir_db_q;
    if (sw_s == dir_db_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_MAX) begin
      dir_db_d  = sw_s;
      deb_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      deb_cnt_q <= '0;
      dir_db_q  <= 1'b0;
      mode_q    <= MODE_WRAP;
      l_q       <= '0;
      pp_dir_q  <= 1'b0;
      event_q   <= 1'b0;
    end else begin
      sync1_q   <= bus.switch_i;
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      deb_cnt_q <= deb_cnt_d;
      dir_db_q  <= dir_db_d;
      event_q   <= 1'b0;
      if (tick_q) begin
        if (mode_in != mode_q) begin
          // A mode change spends its tick loading the start pattern.
          mode_q   <= mode_in;
          l_q      <= (mode_in == MODE_PP) ? ONE : '0;
          pp_dir_q <= 1'b0;
        end else begin
          unique case (mode_q)
            MODE_WRAP: begin
              if (dir_db_q) begin
                l_q     <= l_q - ONE;
                event_q <= (l_q == '0);
              end else begin
                l_q     <= l_q + ONE;
                event_q <= (l_q == ALL_ONES);
              end
            end
            MODE_SAT: begin
              if (!dir_db_q && (l_q != ALL_ONES)) begin
                l_q <= l_q + ONE;
              end else if (dir_db_q && (l_q != '0)) begin
                l_q <= l_q - ONE;
              end
            end
            MODE_PP: begin
              if (!pp_dir_q) begin
                if (l_q[WIDTH-1]) begin
                  pp_dir_q <= 1'b1;
                  l_q      <= l_q >> 1;
                  event_q  <= 1'b1;
                end else begin
                  l_q <= l_q << 1;
                end
              end else begin
                if (l_q[0]) begin
                  pp_dir_q <= 1'b0;
                  l_q      <= l_q << 1;
                  event_q  <= 1'b1;
                end else begin
                  l_q <= l_q >> 1;
                end
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign bus.l_o      = l_q;
  assign bus.tick_o   = tick_q;
  assign bus.dir_db_o = dir_db_q;
  assign bus.event_o  = event_q;
endmodule

// File: tb/tb_led_pattern_counter.sv
// Randomised bench for led_pattern_counter, checked every cycle against a
// behavioural model (edge counts, switch history, LED position arithmetic).
module tb_led_pattern_counter;
  localparam int unsigned W    = 8;
  localparam int unsigned DIV  = 4;
  localparam int unsigned DEB  = 3;
  localparam int          MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_pattern_counter_if #(.WIDTH(W)) bus ();

  led_pattern_counter #(.WIDTH(W), .DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_evt   = 0;

  // Reference state
  int         m_val;
  int         m_pos;
  bit         m_ppdir;
  bit         m_tick;
  bit         m_dir;
  bit         m_event;
  logic [1:0] m_mode;
  int         m_en_edges;
  bit         m_hist[$];
  bit         m_run[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit sw_s;
    bit old_tick;
    bit old_dir;
    old_tick = m_tick;
    old_dir  = m_dir;
    if (rst) begin
      m_val = 0; m_pos = 0; m_ppdir = 0; m_tick = 0; m_dir = 0; m_event = 0;
      m_mode = 2'b00; m_en_edges = 0;
      m_hist = '{1'b0, 1'b0};
      m_run.delete();
      return;
    end
    // Step decided by the tick and direction visible before this edge
    m_event = 0;
    if (old_tick) begin
      if (bus.mode_i != m_mode) begin
        m_mode = bus.mode_i; m_ppdir = 0; m_pos = 0;
        m_val = (bus.mode_i == 2'b10) ? 1 : 0;
      end else begin
        case (m_mode)
          2'b00: begin
            if (!old_dir) begin
              m_event = (m_val == MAXV);
              m_val = (m_val + 1) % (MAXV + 1);
            end else begin
              m_event = (m_val == 0);
              m_val = (m_val + MAXV) % (MAXV + 1);
            end
          end
          2'b01: m_val = old_dir ? ((m_val > 0) ? m_val - 1 : 0)
                                 : ((m_val < MAXV) ? m_val + 1 : MAXV);
          2'b10: begin
            if (!m_ppdir) begin
              if (m_pos == W - 1) begin m_ppdir = 1; m_pos--; m_event = 1; end
              else m_pos++;
            end else begin
              if (m_pos == 0) begin m_ppdir = 0; m_pos++; m_event = 1; end
              else m_pos--;
            end
            m_val = 1 << m_pos;
          end
          default: ;
        endcase
      end
    end
    // Two-stage synchroniser delay, then a run of DEB mismatches flips direction
    sw_s = m_hist.pop_front();
    m_hist.push_back(bus.switch_i);
    if (sw_s == m_dir) m_run.delete();
    else begin
      m_run.push_back(sw_s);
      if (m_run.size() == DEB) begin
        m_dir = sw_s;
        m_run.delete();
      end
    end
    if (bus.en_i) m_en_edges++;
    m_tick = bus.en_i && ((m_en_edges % DIV) == DIV - 1);
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("l",      32'(bus.l_o),      32'(m_val));
    check("tick",   32'(bus.tick_o),   32'(m_tick));
    check("dir_db", 32'(bus.dir_db_o), 32'(m_dir));
    check("event",  32'(bus.event_o),  32'(m_event));
    if (bus.event_o) n_evt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_clk();
    step_clk();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.switch_i = 1'b0;
    bus.en_i     = 1'b1;
    bus.mode_i   = 2'b00;

    // Reset state and free-running up count through the wrap
    do_reset();
    check("rst_l",      32'(bus.l_o),      32'h0);
    check("rst_tick",   32'(bus.tick_o),   32'h0);
    check("rst_dir_db", 32'(bus.dir_db_o), 32'h0);
    check("rst_event",  32'(bus.event_o),  32'h0);
    n_evt = 0;
    run(1040);
    check("wrap_up_events", 32'(n_evt), 32'd1);

    // Debounced down direction crosses 00 -> FF
    bus.switch_i = 1'b1;
    n_evt = 0;
    run(40);
    check("wrap_down_events", 32'(n_evt), 32'd1);

    // Saturating count up then down, never signalling an event
    bus.switch_i = 1'b0;
    bus.mode_i   = 2'b01;
    n_evt = 0;
    run(1240);
    check("sat_top", 32'(bus.l_o), 32'hFF);
    bus.switch_i = 1'b1;
    run(1240);
    check("sat_bottom", 32'(bus.l_o), 32'h00);
    check("sat_events", 32'(n_evt), 32'd0);

    // Ping-pong sweep
    bus.mode_i = 2'b10;
    run(400);

    // Glitch rejection and stable-change latency
    do_reset();
    bus.switch_i = 1'b1;
    run(2);
    bus.switch_i = 1'b0;
    run(10);
    check("glitch_dir_db", 32'(bus.dir_db_o), 32'h0);
    bus.switch_i = 1'b1;
    run(4);
    bus.switch_i = 1'b0;
    run(1);
    check("pulse4_dir_db", 32'(bus.dir_db_o), 32'h1);
    run(10);

    // Enable freeze mid-sweep, then reset mid-sweep
    bus.mode_i = 2'b10;
    run(45);
    bus.en_i = 1'b0;
    run(10);
    bus.en_i = 1'b1;
    run(30);
    rst = 1'b1;
    step_clk();
    check("rst_mid_sweep_l", 32'(bus.l_o), 32'h0);
    rst = 1'b0;
    run(20);

    // Random soak
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.switch_i = ~bus.switch_i;
      bus.en_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) bus.mode_i = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 599) == 0);
      step_clk();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
